// File: rtl/rr_arbiter_pkg.sv
// Shared arbiter constants: request polarity codes, pointer reset value and FSM encodings.
package rr_arbiter_pkg;
  localparam bit ACT_HIGH   = 1'b1;
  localparam bit ACT_LOW    = 1'b0;
  localparam int RR_PTR_RST = 0;

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_BUSY = 1'b1;
endpackage

// File: rtl/rr_arbiter_pri_enc.sv
// Priority encoder: reports the lowest active index of i_in and whether any bit is active.
module pri_enc
  import rr_arbiter_pkg::*;
#(
  parameter int IN  = 4,
  parameter int OUT = 2,
  parameter bit ACT = ACT_HIGH
) (
  input  logic [IN-1:0]  i_in,
  output logic [OUT-1:0] o_idx,
  output logic           o_vld
);
  logic [IN-1:0] w_in;

  assign w_in = ACT ? i_in : ~i_in;

  // Scan high to low so the lowest active index is the last one written.
  always_comb begin
    o_idx = '0;
    o_vld = 1'b0;
    for (int i = IN - 1; i >= 0; i--) begin
      if (w_in[i]) begin
        o_idx = OUT'(i);
        o_vld = 1'b1;
      end
    end
  end
endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter with registered, locked grants; ownership ends on release or request drop.
module rr_arbiter
  import rr_arbiter_pkg::*;
#(
  parameter int REQ = 4,
  parameter int ID  = $clog2(REQ),
  parameter bit ACT = ACT_HIGH
) (
  input  logic           i_clk,
  input  logic           i_reset_,
  input  logic [REQ-1:0] i_req,
  input  logic           i_release,
  output logic [REQ-1:0] o_grant,
  output logic [ID-1:0]  o_grant_id,
  output logic           o_grant_valid
);
  logic [0:0]     r_state;
  logic [ID-1:0]  r_ptr;
  logic [REQ-1:0] r_grant;
  logic [ID-1:0]  r_grant_id;
  logic           r_grant_valid;

  logic [REQ-1:0] w_r, w_c, w_mask, w_m, w_win_oh;
  logic [ID-1:0]  w_m_idx, w_c_idx, w_win, w_ptr_nxt;
  logic           w_m_vld, w_c_vld, w_own_req, w_end;

  assign w_r       = ACT ? i_req : ~i_req;
  assign w_own_req = |(w_r & r_grant);
  assign w_end     = i_release | ~w_own_req;
  // In BUSY the current owner is excluded so the next grant rotates past it.
  assign w_c       = (r_state == S_BUSY) ? (w_r & ~r_grant) : w_r;

  always_comb begin
    w_mask = '0;
    for (int i = 0; i < REQ; i++) w_mask[i] = (ID'(i) >= r_ptr);
  end

  assign w_m = w_c & w_mask;

  pri_enc #(.IN(REQ), .OUT(ID), .ACT(ACT_HIGH)) u_enc_m (
    .i_in (w_m),
    .o_idx(w_m_idx),
    .o_vld(w_m_vld)
  );

  pri_enc #(.IN(REQ), .OUT(ID), .ACT(ACT_HIGH)) u_enc_c (
    .i_in (w_c),
    .o_idx(w_c_idx),
    .o_vld(w_c_vld)
  );

  assign w_win     = w_m_vld ? w_m_idx : w_c_idx;
  assign w_win_oh  = REQ'(1) << w_win;
  assign w_ptr_nxt = (w_win == ID'(REQ - 1)) ? '0 : w_win + ID'(1);

  always_ff @(posedge i_clk) begin
    if (!i_reset_) begin
      r_state       <= S_IDLE;
      r_ptr         <= ID'(RR_PTR_RST);
      r_grant       <= '0;
      r_grant_id    <= '0;
      r_grant_valid <= 1'b0;
    end else if ((r_state == S_IDLE) || w_end) begin
      if (w_c_vld) begin
        r_state       <= S_BUSY;
        r_ptr         <= w_ptr_nxt;
        r_grant       <= w_win_oh;
        r_grant_id    <= w_win;
        r_grant_valid <= 1'b1;
      end else begin
        r_state       <= S_IDLE;
        r_grant       <= '0;
        r_grant_id    <= '0;
        r_grant_valid <= 1'b0;
      end
    end
  end

  assign o_grant       = r_grant;
  assign o_grant_id    = r_grant_id;
  assign o_grant_valid = r_grant_valid;
endmodule

// File: tb/tb_rr_arbiter.sv
// Bench for rr_arbiter: cyclic-search reference model checked every cycle, plus directed literal checks.
module tb_rr_arbiter;
  import rr_arbiter_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] req, req_l;
  logic       rel, rel_l;
  logic [3:0] grant, grant_l;
  logic [1:0] gid, gid_l;
  logic       gvld, gvld_l;

  int total = 0;
  int bad   = 0;
  bit started = 1'b0;

  int m_own = -1;
  int m_ptr = 0;

  rr_arbiter #(.REQ(4), .ACT(ACT_HIGH)) dut (
    .i_clk(clk), .i_reset_(rst_n), .i_req(req), .i_release(rel),
    .o_grant(grant), .o_grant_id(gid), .o_grant_valid(gvld)
  );

  rr_arbiter #(.REQ(4), .ACT(ACT_LOW)) dut_l (
    .i_clk(clk), .i_reset_(rst_n), .i_req(req_l), .i_release(rel_l),
    .o_grant(grant_l), .o_grant_id(gid_l), .o_grant_valid(gvld_l)
  );

  always #5 clk = ~clk;

  // First requester found walking cyclically from p, skipping excl.
  function automatic int pick(input logic [3:0] r, input int excl, input int p);
    for (int s = 0; s < 4; s++) begin
      int k;
      k = (p + s) % 4;
      if (r[k] && k != excl) return k;
    end
    return -1;
  endfunction

  always @(posedge clk) begin
    int k;
    if (!rst_n) begin
      m_own = -1;
      m_ptr = 0;
    end else if (m_own < 0) begin
      k = pick(req, -1, m_ptr);
      if (k >= 0) begin
        m_own = k;
        m_ptr = (k + 1) % 4;
      end
    end else if (rel || !req[m_own]) begin
      k = pick(req, m_own, m_ptr);
      m_own = k;
      if (k >= 0) m_ptr = (k + 1) % 4;
    end
  end

  always @(negedge clk) begin
    if (started) begin
      logic [6:0] exp_v, act_v;
      exp_v = (m_own < 0) ? 7'b0 : {4'(1 << m_own), 2'(m_own), 1'b1};
      act_v = {grant, gid, gvld};
      total++;
      if (act_v !== exp_v) begin
        bad++;
        $display("FAIL model t=%0t {grant,id,valid} got=%b want=%b", $time, act_v, exp_v);
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", nm, act, exp);
    end
  endtask

  task automatic step(input logic rn, input logic [3:0] rq, input logic rl);
    rst_n = rn;
    req   = rq;
    rel   = rl;
    @(posedge clk);
    #1;
    started = 1'b1;
  endtask

  initial begin
    req_l = 4'b1111;
    rel_l = 1'b0;
    // Reset dominates a full request vector.
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 4'b1111, 1'b0);
      chk("rst_grant", 32'(grant), 32'h0);
      chk("rst_id", 32'(gid), 32'h0);
      chk("rst_vld", 32'(gvld), 32'h0);
    end
    step(1'b1, 4'b1111, 1'b0);
    chk("post_rst_grant", 32'(grant), 32'h1);
    step(1'b1, 4'b0000, 1'b0);
    chk("drop_to_idle", 32'(grant), 32'h0);

    // Single requester held, then released while still requesting.
    step(1'b1, 4'b0100, 1'b0);
    chk("single_grant", 32'(grant), 32'h4);
    chk("single_id", 32'(gid), 32'h2);
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 4'b0100, 1'b0);
      chk("single_hold", 32'(grant), 32'h4);
    end
    step(1'b1, 4'b0100, 1'b1);
    chk("sole_release_gap", 32'(grant), 32'h0);
    step(1'b1, 4'b0100, 1'b0);
    chk("sole_regrant", 32'(grant), 32'h4);

    // Fair rotation from a fresh pointer.
    step(1'b0, 4'b0000, 1'b0);
    begin
      logic [1:0] seq [6];
      seq = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
      for (int i = 0; i < 6; i++) begin
        step(1'b1, 4'b1111, 1'b1);
        chk("rotate_id", 32'(gid), 32'(seq[i]));
        chk("rotate_vld", 32'(gvld), 32'h1);
      end
    end

    // Owner 1 released with 0111 -> owner 2; then implicit release wraps to 0.
    step(1'b1, 4'b0111, 1'b1);
    chk("to_owner2", 32'(gid), 32'h2);
    step(1'b1, 4'b0011, 1'b0);
    chk("implicit_wrap", 32'(gid), 32'h0);
    step(1'b1, 4'b0010, 1'b1);
    chk("release_to_1", 32'(gid), 32'h1);

    // No preemption: owner 1 keeps grant while others request.
    step(1'b1, 4'b1111, 1'b0);
    chk("no_preempt", 32'(gid), 32'h1);

    // Reset mid-grant with owner 3.
    step(1'b1, 4'b1000, 1'b0);
    chk("owner3", 32'(grant), 32'h8);
    step(1'b0, 4'b1000, 1'b0);
    chk("mid_rst_grant", 32'(grant), 32'h0);
    chk("mid_rst_vld", 32'(gvld), 32'h0);
    step(1'b1, 4'b1010, 1'b0);
    chk("ptr_restored", 32'(gid), 32'h1);

    // Mixed traffic checked by the model only.
    for (int i = 0; i < 300; i++)
      step(1'b1, 4'($urandom_range(0, 15)), ($urandom_range(0, 3) == 0));

    // Active-low instance.
    req_l = 4'b1011;
    step(1'b1, 4'b0000, 1'b0);
    chk("low_grant", 32'(grant_l), 32'h4);
    chk("low_id", 32'(gid_l), 32'h2);
    req_l = 4'b1111;
    rel_l = 1'b1;
    step(1'b1, 4'b0000, 1'b0);
    chk("low_idle", 32'(grant_l), 32'h0);
    chk("low_vld", 32'(gvld_l), 32'h0);

    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/rr_arbiter.md
Name: rr_arbiter

Overview:
- Round-robin arbiter that shares one resource among REQ requesters.
- Built around the codebase's priority encoder, which does the masked and unmasked winner search.
- Grants are registered and locked until the owner releases, so it sits in front of shared buses, ports and functional units.
- Fairness rotates past the last owner, so no requester starves.

Parameters:
- REQ, 4: number of requesters (≥2; need not be a power of 2).
- ID, $clog2(REQ): width of grant_id.
- ACT, `High: request polarity. `High means req bit =1 requests; `Low means req bit =0 requests. Grant outputs are always active-high.

Ports:
- clk, input, 1: clock, rising edge.
- reset_, input, 1: reset, synchronous, active-low.
- req, input, REQ: per-requester request, polarity per ACT.
- release, input, 1: owner finishes the transaction this cycle; active-high.
- grant, output, REQ: one-hot grant, registered.
- grant_id, output, ID: index of the granted requester, registered.
- grant_valid, output, 1: grant is nonzero, registered.

Behaviour:
- Reset (reset_=0 at a rising edge):
  - grant=0, grant_id=0, grant_valid=0, ptr=0, state=IDLE.
  - Reset wins over every other input, including mid-grant. Outputs clear at that edge with no release handshake.
- Internal request vector:
  - r = req when ACT=`High, r = ~req when ACT=`Low.
  - Everything below uses r.
- Round-robin pointer ptr (ID bits):
  - ptr marks the highest-priority index.
  - On each new grant to index k: ptr <= (k==REQ-1) ? 0 : k+1. Wrap is explicit and independent of the power of 2.
- Winner selection (combinational) from candidate vector c:
  - m = c & thermometer mask of bits ≥ ptr.
  - If m≠0, winner = lowest set index of m; otherwise winner = lowest set index of c.
  - Each search is one priority-encoder instance; lowest index wins.
- States:
  - IDLE:
    - If r≠0: grant the winner from c=r at the next edge (grant_valid=1), go to BUSY.
    - Else stay IDLE with outputs 0.
    - release is ignored in IDLE.
  - BUSY:
    - Grant outputs hold stable while the owner's r bit=1 and release=0.
    - End of ownership happens when release=1 OR the owner's r bit=0 (implicit release).
    - On end of ownership, use c = r & ~grant. If c≠0, grant its winner at the next edge and stay BUSY (back-to-back, no bubble).
    - If c=0: grant=0, grant_valid=0 at the next edge, go to IDLE.
    - Consequence: a sole requester that releases and keeps requesting sees one idle cycle, then is regranted.
- Latency:
  - Request to grant is 1 cycle from IDLE.
  - Release to next owner's grant is 1 cycle.
- Invariants:
  - grant is one-hot or zero.
  - grant_valid == |grant.
  - grant_id matches grant; grant_id=0 when grant=0.
  - A request arriving while BUSY never preempts the owner.
- Non-requester req bits changing during BUSY have no effect until end of ownership.

Decomposition:
- Shared header `stddef.vh` already supplies `High/`Low; no new typedefs.
- Add a shared constant RR_PTR_RST=0 to the common arbiter header, for reuse by future arbiters.
- Sub-module: reuse pri_enc (IN=REQ, OUT=ID, ACT=`High), instantiated twice (masked and unmasked).
  - Required priority is lowest index. Bit-reverse the input and output if the encoder's native priority differs.
  - The encoder's valid output feeds the m≠0 / c≠0 decisions.
- FSM, ptr, mask generation and output registers stay in rr_arbiter (estimated 150–250 lines).

Test Plan (REQ=4, ACT=`High unless stated):
- Reset priority: reset_=0 with req=4'b1111 held 3 cycles -> grant=0, grant_id=0, grant_valid=0 every cycle. After reset_=1, grant=4'b0001 one cycle later.
- Single request and hold: req=4'b0100 at cycle N, release=0 -> grant=4'b0100, grant_id=2 from N+1 and stable for 10 cycles. Asserting release=1 with req=4'b0100 still high -> grant=0 next cycle, grant=4'b0100 again the cycle after.
- Fair rotation: req=4'b1111 constant, release=1 every cycle while BUSY -> grant_id sequence 0,1,2,3,0,1 on consecutive cycles, no gaps.
- Wrap and implicit release:
  - Owner 2 (ptr=3), req changes 4'b0111 -> 4'b0011 with release=0 -> grant_id=0 next cycle.
  - Then req=4'b0010, release=1 -> grant_id=1.
- Reset mid-grant: owner 3 granted, reset_=0 for one cycle -> next edge all outputs 0. After reset_=1 with req=4'b1010 -> grant_id=1, confirming ptr restored to 0.
- ACT=`Low: req=4'b1011 (requester 2 active) -> grant=4'b0100 one cycle later. req=4'b1111 plus release -> IDLE, grant=0.
